// File: rtl/aes_round_ctrl.sv
// Step sequencer for an iterative AES-128 round datapath: walks cs/count through
// the initial AddRoundKey, NR-1 full rounds and a final round without MixColumns.
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic          abort,
    output logic [2:0]    cs,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done_valid,
    input  logic          done_ready
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT_ADD = 3'd1,
        S_SUB      = 3'd2,
        S_SHI      = 3'd3,
        S_MIX      = 3'd4,
        S_ADD      = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [2:0]    CS_RES = 3'b000;
    localparam logic [2:0]    CS_ADD = 3'b001;
    localparam logic [2:0]    CS_SUB = 3'b010;
    localparam logic [2:0]    CS_SHI = 3'b100;
    localparam logic [2:0]    CS_MIX = 3'b101;
    localparam logic [2:0]    CS_FIN = 3'b111;
    localparam logic [CW-1:0] NR_C   = CW'(NR);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    cs_q, cs_d;
    logic          busy_q, busy_d;
    logic          done_valid_q, done_valid_d;
    logic          start_ready_q, start_ready_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (start_valid) state_d = S_INIT_ADD;
            end
            S_INIT_ADD: begin
                state_d = S_SUB;
                count_d = CW'(1);
            end
            S_SUB: state_d = S_SHI;
            S_SHI: state_d = (count_q < NR_C) ? S_MIX : S_ADD;
            S_MIX: state_d = S_ADD;
            S_ADD: begin
                if (count_q < NR_C) begin
                    state_d = S_SUB;
                    count_d = count_q + 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (done_ready) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
        // Abort wins over everything except an accept from IDLE.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            count_d = '0;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        cs_d = CS_RES;
        case (state_d)
            S_INIT_ADD: cs_d = CS_ADD;
            S_SUB:      cs_d = CS_SUB;
            S_SHI:      cs_d = CS_SHI;
            S_MIX:      cs_d = CS_MIX;
            S_ADD:      cs_d = CS_ADD;
            S_DONE:     cs_d = CS_FIN;
            default:    cs_d = CS_RES;
        endcase
        start_ready_d = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        done_valid_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            cs_q          <= CS_RES;
            busy_q        <= 1'b0;
            done_valid_q  <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            cs_q          <= cs_d;
            busy_q        <= busy_d;
            done_valid_q  <= done_valid_d;
            start_ready_q <= start_ready_d;
        end
    end

    assign cs          = cs_q;
    assign count       = count_q;
    assign busy        = busy_q;
    assign done_valid  = done_valid_q;
    assign start_ready = start_ready_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: schedule, backpressure, back-to-back,
// abort and asynchronous reset scenarios with hand-derived expectations.
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic       abort;
    logic [2:0] cs;
    logic [7:0] count;
    logic       busy;
    logic       done_valid;
    logic       done_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int k        = 0;

    aes_round_ctrl #(.NR(10), .CW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .abort       (abort),
        .cs          (cs),
        .count       (count),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Accept edge is E0; afterwards k is the cycle number within the run.
    task automatic start_run();
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        k = 1;
        $display("txn start accepted at cyc %0d", cyc);
    endtask

    task automatic advance_to(input int target);
        while (k < target) begin
            step();
            k++;
        end
    endtask

    // Cycle 1 INIT_ADD, rounds 1-9 four cycles each, round 10 three cycles, 41 DONE.
    function automatic logic [2:0] exp_cs(input int kk);
        if (kk == 1) return 3'b001;
        if (kk <= 37) begin
            case ((kk - 2) % 4)
                0:       return 3'b010;
                1:       return 3'b100;
                2:       return 3'b101;
                default: return 3'b001;
            endcase
        end
        if (kk == 38) return 3'b010;
        if (kk == 39) return 3'b100;
        if (kk == 40) return 3'b001;
        return 3'b111;
    endfunction

    function automatic logic [7:0] exp_cnt(input int kk);
        if (kk == 1) return 8'd0;
        if (kk <= 37) return 8'((kk - 2) / 4 + 1);
        return 8'd10;
    endfunction

    task automatic check_idle(input string tag);
        n_checks++;
        if ({cs, count, busy, done_valid, start_ready} !== {3'b000, 8'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL %s: cs=%b count=%0d busy=%b dv=%b sr=%b, required cs=000 count=0 busy=0 dv=0 sr=1",
                     tag, cs, count, busy, done_valid, start_ready);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        start_valid = 1'b0;
        abort       = 1'b0;
        done_ready  = 1'b0;
        #12;
        check_idle("reset_held");
        #5 rst_n = 1'b1;
        step();
        check_idle("reset_released");
        $display("txn reset done");
    endtask

    task automatic test_single_block();
        done_ready = 1'b1;
        start_run();
        for (int kk = 1; kk <= 41; kk++) begin
            advance_to(kk);
            n_checks++;
            if (cs !== exp_cs(kk) || count !== exp_cnt(kk)) begin
                n_fail++;
                $display("FAIL single_sched k=%0d: cs=%b count=%0d, required cs=%b count=%0d",
                         kk, cs, count, exp_cs(kk), exp_cnt(kk));
            end
            n_checks++;
            if (done_valid !== (kk == 41) || busy !== 1'b1 || start_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL single_hs k=%0d: dv=%b busy=%b sr=%b, required dv=%b busy=1 sr=0",
                         kk, done_valid, busy, start_ready, (kk == 41));
            end
        end
        step();
        check_idle("single_after_done");
        $display("txn single block complete");
    endtask

    task automatic test_backpressure();
        done_ready = 1'b0;
        start_run();
        advance_to(41);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (done_valid !== 1'b1 || cs !== 3'b111 || count !== 8'd10) begin
                n_fail++;
                $display("FAIL bp_hold i=%0d: dv=%b cs=%b count=%0d, required dv=1 cs=111 count=10",
                         i, done_valid, cs, count);
            end
            step();
        end
        n_checks++;
        if (done_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold_last: dv=%b, required 1", done_valid);
        end
        done_ready = 1'b1;
        step();
        check_idle("bp_release");
        $display("txn backpressure complete");
    endtask

    task automatic test_back_to_back();
        int acc[3];
        int n_acc = 0;
        done_ready  = 1'b1;
        start_valid = 1'b1;
        for (int i = 0; i < 200 && n_acc < 3; i++) begin
            if (start_ready === 1'b1) begin
                acc[n_acc] = cyc;
                n_acc++;
                $display("txn b2b accept at cyc %0d", cyc);
            end
            step();
        end
        start_valid = 1'b0;
        n_checks++;
        if (n_acc != 3) begin
            n_fail++;
            $display("FAIL b2b_count: accepts=%0d, required 3", n_acc);
        end else begin
            n_checks++;
            if (acc[1] - acc[0] != 42 || acc[2] - acc[1] != 42) begin
                n_fail++;
                $display("FAIL b2b_spacing: gaps=%0d,%0d, required 42,42",
                         acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
        // Drain the third run via abort.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("b2b_drain");
    endtask

    task automatic test_abort_mix();
        done_ready = 1'b1;
        start_run();
        advance_to(20);
        n_checks++;
        if (cs !== 3'b101 || count !== 8'd5) begin
            n_fail++;
            $display("FAIL abort_pre: cs=%b count=%0d, required cs=101 count=5", cs, count);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort_mix");
        start_run();
        for (int kk = 1; kk <= 41; kk++) begin
            advance_to(kk);
            n_checks++;
            if (done_valid !== (kk == 41)) begin
                n_fail++;
                $display("FAIL abort_rerun_dv k=%0d: dv=%b, required %b", kk, done_valid, (kk == 41));
            end
        end
        step();
        check_idle("abort_rerun_done");
        $display("txn abort in MIX complete");
    endtask

    task automatic test_async_reset();
        int seen_dv = 0;
        done_ready = 1'b1;
        start_run();
        advance_to(11);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_reset_low");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (done_valid === 1'b1) seen_dv++;
        end
        n_checks++;
        if (seen_dv != 0) begin
            n_fail++;
            $display("FAIL async_reset_no_dv: dv cycles=%0d, required 0", seen_dv);
        end
        check_idle("async_reset_after");
        $display("txn async reset complete");
    endtask

    task automatic test_abort_priority();
        done_ready = 1'b1;
        start_run();
        advance_to(41);
        n_checks++;
        if (done_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_done: dv=%b, required 1", done_valid);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("prio_abort_done_ready");
        abort       = 1'b1;
        start_valid = 1'b1;
        step();
        abort       = 1'b0;
        start_valid = 1'b0;
        n_checks++;
        if (cs !== 3'b001 || busy !== 1'b1 || start_ready !== 1'b0 || count !== 8'd0) begin
            n_fail++;
            $display("FAIL prio_idle_abort_start: cs=%b busy=%b sr=%b count=%0d, required cs=001 busy=1 sr=0 count=0",
                     cs, busy, start_ready, count);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("prio_cleanup");
        $display("txn abort priority complete");
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_back_to_back();
        test_abort_mix();
        test_async_reset();
        test_abort_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
